// File: rtl/maze_pkg.sv
// Shared defaults, colour constants and enumerations for the maze frame renderer.
package maze_pkg;

    localparam int DEF_COLS      = 21;
    localparam int DEF_ROWS      = 31;
    localparam int DEF_CELL_PX   = 8;
    localparam int DEF_BPP_BYTES = 2;

    localparam logic [15:0] DEF_WALL_COLOR = 16'h07E0;
    localparam logic [15:0] DEF_FOOD_COLOR = 16'hF800;
    localparam logic [15:0] DEF_BG_COLOR   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_ACK,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        CLS_BG   = 2'd0,
        CLS_WALL = 2'd1,
        CLS_FOOD = 2'd2
    } pix_class_t;

endpackage

// File: rtl/maze_pixel_classifier.sv
// Combinational wall/food/background decision for one pixel, given its cell and in-cell offsets.
module maze_pixel_classifier
    import maze_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int CELL_PX = DEF_CELL_PX
) (
    input  logic [$clog2(CELL_PX)-1:0]   lx,
    input  logic [$clog2(CELL_PX)-1:0]   ly,
    input  logic [$clog2(COLS)-1:0]      col,
    input  logic [$clog2(ROWS)-1:0]      row,
    input  logic [(ROWS-1)*COLS-1:0]     h_walls,
    input  logic [ROWS*(COLS-1)-1:0]     v_walls,
    input  logic [ROWS*COLS-1:0]         food,
    output pix_class_t                   pix_class
);

    localparam int IW  = $clog2(ROWS*COLS);
    localparam int LXW = $clog2(CELL_PX);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int HW  = (ROWS-1)*COLS;
    localparam int VW  = ROWS*(COLS-1);
    localparam int FW  = ROWS*COLS;

    logic [IW-1:0] cell_idx;
    logic [IW-1:0] h_idx;
    logic [IW-1:0] v_idx;
    logic          h_bit;
    logic          v_bit;
    logic          f_bit;
    logic          wall_w;
    logic          wall_n;
    logic          wall_e;
    logic          wall_s;
    logic          in_lx;
    logic          in_ly;

    // The wall indices are forced to 0 on the first row/column, so no negative index is ever formed.
    assign cell_idx = IW'(row) * IW'(COLS) + IW'(col);
    assign h_idx    = (row == '0) ? '0 : cell_idx - IW'(COLS);
    assign v_idx    = (col == '0) ? '0 : IW'(row) * IW'(COLS-1) + IW'(col) - IW'(1);

    assign h_bit = |(h_walls & (HW'(1) << h_idx));
    assign v_bit = |(v_walls & (VW'(1) << v_idx));
    assign f_bit = |(food    & (FW'(1) << cell_idx));

    assign wall_w = (lx == '0) && ((col == '0) || v_bit);
    assign wall_n = (ly == '0) && ((row == '0) || h_bit);
    assign wall_e = (col == CW'(COLS-1)) && (lx == LXW'(CELL_PX-1));
    assign wall_s = (row == RW'(ROWS-1)) && (ly == LXW'(CELL_PX-1));

    assign in_lx = (lx >= LXW'(CELL_PX/4)) && (lx < LXW'(3*CELL_PX/4));
    assign in_ly = (ly >= LXW'(CELL_PX/4)) && (ly < LXW'(3*CELL_PX/4));

    always_comb begin
        pix_class = CLS_BG;
        if (wall_w || wall_n || wall_e || wall_s || ((lx == '0) && (ly == '0))) begin
            pix_class = CLS_WALL;
        end else if (f_bit && in_lx && in_ly) begin
            pix_class = CLS_FOOD;
        end
    end

endmodule

// File: rtl/maze_renderer.sv
// Streams one raster frame of maze pixels, MSB byte first, through the tft_transmit/tft_busy handshake.
module maze_renderer
    import maze_pkg::*;
#(
    parameter int                     COLS       = DEF_COLS,
    parameter int                     ROWS       = DEF_ROWS,
    parameter int                     CELL_PX    = DEF_CELL_PX,
    parameter int                     BPP_BYTES  = DEF_BPP_BYTES,
    parameter logic [8*BPP_BYTES-1:0] WALL_COLOR = DEF_WALL_COLOR,
    parameter logic [8*BPP_BYTES-1:0] FOOD_COLOR = DEF_FOOD_COLOR,
    parameter logic [8*BPP_BYTES-1:0] BG_COLOR   = DEF_BG_COLOR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          enable,
    input  logic [(ROWS-1)*COLS-1:0]      h_walls,
    input  logic [ROWS*(COLS-1)-1:0]      v_walls,
    input  logic [ROWS*COLS-1:0]          food,
    input  logic                          tft_busy,
    output logic                          tft_dc,
    output logic [7:0]                    tft_data,
    output logic                          tft_transmit,
    output logic                          busy,
    output logic                          done
);

    localparam int LXW = $clog2(CELL_PX);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int PW  = 8*BPP_BYTES;
    localparam int BIW = (BPP_BYTES > 1) ? $clog2(BPP_BYTES) : 1;

    state_t             state_reg, state_next;
    logic [LXW-1:0]     lx_reg, lx_next;
    logic [LXW-1:0]     ly_reg, ly_next;
    logic [CW-1:0]      col_reg, col_next;
    logic [RW-1:0]      row_reg, row_next;
    logic [BIW-1:0]     byte_idx_reg, byte_idx_next;
    logic [PW-1:0]      pix_reg, pix_next;
    logic               done_reg, done_next;

    pix_class_t         pix_class;
    logic [PW-1:0]      pix_color;
    logic [7:0]         pix_bytes [BPP_BYTES];
    logic               lx_last, ly_last, col_last, row_last, last_byte;

    maze_pixel_classifier #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .CELL_PX (CELL_PX)
    ) u_classifier (
        .lx        (lx_reg),
        .ly        (ly_reg),
        .col       (col_reg),
        .row       (row_reg),
        .h_walls   (h_walls),
        .v_walls   (v_walls),
        .food      (food),
        .pix_class (pix_class)
    );

    always_comb begin
        pix_color = BG_COLOR;
        case (pix_class)
            CLS_WALL: pix_color = WALL_COLOR;
            CLS_FOOD: pix_color = FOOD_COLOR;
            default:  pix_color = BG_COLOR;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BPP_BYTES; gi++) begin : g_byte_mux
            assign pix_bytes[gi] = pix_reg[8*(BPP_BYTES-1-gi) +: 8];
        end
    endgenerate

    assign lx_last   = (lx_reg  == LXW'(CELL_PX-1));
    assign ly_last   = (ly_reg  == LXW'(CELL_PX-1));
    assign col_last  = (col_reg == CW'(COLS-1));
    assign row_last  = (row_reg == RW'(ROWS-1));
    assign last_byte = (byte_idx_reg == BIW'(BPP_BYTES-1));

    always_comb begin
        state_next    = state_reg;
        lx_next       = lx_reg;
        ly_next       = ly_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        byte_idx_next = byte_idx_reg;
        pix_next      = pix_reg;
        done_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                // Colour is latched only when leaving LOAD so all bytes of a pixel share one colour.
                if (enable && !tft_busy) begin
                    pix_next      = pix_color;
                    byte_idx_next = '0;
                    state_next    = ST_SEND;
                end
            end
            ST_SEND: state_next = ST_ACK;
            ST_ACK: begin
                if (tft_busy) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tft_busy) begin
                    if (!last_byte) begin
                        if (enable) begin
                            byte_idx_next = byte_idx_reg + 1'b1;
                            state_next    = ST_SEND;
                        end
                    end else begin
                        lx_next = lx_last ? '0 : lx_reg + 1'b1;
                        if (lx_last) begin
                            col_next = col_last ? '0 : col_reg + 1'b1;
                            if (col_last) begin
                                ly_next = ly_last ? '0 : ly_reg + 1'b1;
                                if (ly_last) row_next = row_last ? '0 : row_reg + 1'b1;
                            end
                        end
                        if (lx_last && col_last && ly_last && row_last) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lx_reg       <= '0;
            ly_reg       <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            byte_idx_reg <= '0;
            pix_reg      <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lx_reg       <= lx_next;
            ly_reg       <= ly_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            byte_idx_reg <= byte_idx_next;
            pix_reg      <= pix_next;
            done_reg     <= done_next;
        end
    end

    assign tft_dc       = 1'b1;
    assign tft_data     = pix_bytes[byte_idx_reg];
    assign tft_transmit = (state_reg == ST_SEND);
    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;

endmodule

// File: tb/tb_maze_renderer.sv
// Directed bench: a 2x2-cell/4px/2-byte renderer for the handshake scenarios and a 3x2-cell/8px/3-byte one.
module tb_maze_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       enable = 1'b1;

    // Instance A: COLS=2 ROWS=2 CELL_PX=4 BPP=2, default colours
    logic       start_a = 1'b0;
    logic [1:0] h_a = '0;
    logic [1:0] v_a = '0;
    logic [3:0] food_a = '0;
    logic       tft_busy_a, tft_dc_a, tft_transmit_a, busy_a, done_a;
    logic [7:0] tft_data_a;

    // Instance B: COLS=3 ROWS=2 CELL_PX=8 BPP=3
    logic       start_b = 1'b0;
    logic [2:0] h_b = '0;
    logic [3:0] v_b = '0;
    logic [5:0] food_b = '0;
    logic       tft_busy_b, tft_dc_b, tft_transmit_b, busy_b, done_b;
    logic [7:0] tft_data_b;

    maze_renderer #(.COLS(2), .ROWS(2), .CELL_PX(4), .BPP_BYTES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .enable(enable),
        .h_walls(h_a), .v_walls(v_a), .food(food_a), .tft_busy(tft_busy_a),
        .tft_dc(tft_dc_a), .tft_data(tft_data_a), .tft_transmit(tft_transmit_a),
        .busy(busy_a), .done(done_a)
    );

    maze_renderer #(.COLS(3), .ROWS(2), .CELL_PX(8), .BPP_BYTES(3),
                    .WALL_COLOR(24'h0A0B0C), .FOOD_COLOR(24'h102030), .BG_COLOR(24'h445566)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .enable(1'b1),
        .h_walls(h_b), .v_walls(v_b), .food(food_b), .tft_busy(tft_busy_b),
        .tft_dc(tft_dc_b), .tft_data(tft_data_b), .tft_transmit(tft_transmit_b),
        .busy(busy_b), .done(done_b)
    );

    // TFT driver models: busy for 3 cycles starting the cycle after a strobe is sampled.
    logic [7:0] cap_a [0:4095];
    logic [7:0] cap_b [0:2047];
    int ncap_a = 0, ncap_b = 0, bcnt_a = 0, bcnt_b = 0, done_a_cnt = 0, done_b_cnt = 0;

    assign tft_busy_a = (bcnt_a != 0);
    assign tft_busy_b = (bcnt_b != 0);

    always @(posedge clk) begin
        if (tft_transmit_a) begin
            if (ncap_a < 4096) cap_a[ncap_a] <= tft_data_a;
            ncap_a <= ncap_a + 1;
            bcnt_a <= 3;
        end else if (bcnt_a != 0) begin
            bcnt_a <= bcnt_a - 1;
        end
        if (tft_transmit_b) begin
            if (ncap_b < 2048) cap_b[ncap_b] <= tft_data_b;
            ncap_b <= ncap_b + 1;
            bcnt_b <= 3;
        end else if (bcnt_b != 0) begin
            bcnt_b <= bcnt_b - 1;
        end
        if (done_a) done_a_cnt <= done_a_cnt + 1;
        if (done_b) done_b_cnt <= done_b_cnt + 1;
    end

    int checks = 0;
    int passed = 0;

    // Instance A with every wall input 0 and no food: only borders and corner posts are walls.
    function automatic logic [15:0] exp_open_a(input int x, input int y);
        if (x == 0 || y == 0 || x == 7 || y == 7 || (x % 4 == 0 && y % 4 == 0)) return 16'h07E0;
        return 16'h0000;
    endfunction

    // Instance B with all walls and all food set.
    function automatic logic [23:0] exp_full_b(input int x, input int y);
        int lx, ly;
        lx = x % 8;
        ly = y % 8;
        if (lx == 0 || ly == 0 || x == 23 || y == 15) return 24'h0A0B0C;
        if (lx >= 2 && lx < 6 && ly >= 2 && ly < 6) return 24'h102030;
        return 24'h445566;
    endfunction

    task automatic run_frame_a(input int budget, output int base, output bit ok);
        base = ncap_a;
        ok = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tft_transmit_a !== 1'b0) $display("FAIL reset_transmit: got %b want 0", tft_transmit_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
        checks++; if (tft_data_a !== 8'h00) $display("FAIL reset_data: got %h want 00", tft_data_a); else passed++;
        checks++; if (tft_dc_a !== 1'b1) $display("FAIL reset_dc: got %b want 1", tft_dc_a); else passed++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || ncap_a !== 0) $display("FAIL idle_after_reset: busy %b strobes %0d want 0/0", busy_a, ncap_a); else passed++;
    endtask

    task automatic test_basic_frame;
        int base, d0;
        bit ok;
        h_a = '0; v_a = '0; food_a = '0;
        d0 = done_a_cnt;
        run_frame_a(3000, base, ok);
        $display("frame1: base %0d bytes %0d done %0b", base, ncap_a - base, ok);
        checks++; if (ok !== 1'b1) $display("FAIL frame1_done_seen: got %b want 1", ok); else passed++;
        checks++; if (ncap_a - base !== 128) $display("FAIL frame1_bytes: got %0d want 128", ncap_a - base); else passed++;
        checks++; if (done_a_cnt - d0 !== 1) $display("FAIL frame1_done_count: got %0d want 1", done_a_cnt - d0); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL frame1_busy_after: got %b want 0", busy_a); else passed++;
        checks++; if ({cap_a[base], cap_a[base+1]} !== 16'h07E0) $display("FAIL frame1_corner: got %h want 07e0", {cap_a[base], cap_a[base+1]}); else passed++;
        checks++; if ({cap_a[base+18], cap_a[base+19]} !== 16'h0000) $display("FAIL frame1_px_1_1: got %h want 0000", {cap_a[base+18], cap_a[base+19]}); else passed++;
    endtask

    task automatic test_walls;
        int base;
        bit ok;
        v_a = 2'b01; h_a = '0; food_a = '0;
        run_frame_a(3000, base, ok);
        $display("vwall frame: base %0d bytes %0d", base, ncap_a - base);
        checks++; if ({cap_a[base+24], cap_a[base+25]} !== 16'h07E0 || !ok) $display("FAIL vwall_px_4_1: got %h want 07e0", {cap_a[base+24], cap_a[base+25]}); else passed++;
        v_a = 2'b00; h_a = 2'b10;
        run_frame_a(3000, base, ok);
        $display("hwall frame: base %0d bytes %0d", base, ncap_a - base);
        checks++; if ({cap_a[base+24], cap_a[base+25]} !== 16'h0000 || !ok) $display("FAIL novwall_px_4_1: got %h want 0000", {cap_a[base+24], cap_a[base+25]}); else passed++;
        checks++; if ({cap_a[base+74], cap_a[base+75]} !== 16'h07E0) $display("FAIL hwall_px_5_4: got %h want 07e0", {cap_a[base+74], cap_a[base+75]}); else passed++;
    endtask

    task automatic test_food;
        int base;
        bit ok;
        food_a = 4'b1000; v_a = 2'b10; h_a = 2'b00;
        run_frame_a(3000, base, ok);
        $display("food frame: base %0d bytes %0d", base, ncap_a - base);
        checks++; if ({cap_a[base+90], cap_a[base+91]} !== 16'hF800 || !ok) $display("FAIL food_px_5_5: got %h want f800", {cap_a[base+90], cap_a[base+91]}); else passed++;
        checks++; if ({cap_a[base+108], cap_a[base+109]} !== 16'hF800) $display("FAIL food_px_6_6: got %h want f800", {cap_a[base+108], cap_a[base+109]}); else passed++;
        checks++; if ({cap_a[base+88], cap_a[base+89]} !== 16'h07E0) $display("FAIL food_wall_px_4_5: got %h want 07e0", {cap_a[base+88], cap_a[base+89]}); else passed++;
        checks++; if ({cap_a[base+126], cap_a[base+127]} !== 16'h07E0) $display("FAIL food_border_px_7_7: got %h want 07e0", {cap_a[base+126], cap_a[base+127]}); else passed++;
        checks++; if ({cap_a[base+74], cap_a[base+75]} !== 16'h0000) $display("FAIL food_edge_px_5_4: got %h want 0000", {cap_a[base+74], cap_a[base+75]}); else passed++;
        food_a = '0; v_a = '0;
    endtask

    task automatic test_pause;
        int base, d0, n1, strobes, bad, after;
        bit reached, ok;
        h_a = '0; v_a = '0; food_a = '0;
        base = ncap_a;
        d0 = done_a_cnt;
        reached = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ncap_a - base >= 40) begin
                reached = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n1 = ncap_a;
        strobes = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (tft_transmit_a) strobes++;
            start_a = (i == 10);
        end
        start_a = 1'b0;
        $display("pause: bytes before %0d strobes while paused %0d", n1 - base, strobes);
        checks++; if (strobes !== 0 || ncap_a !== n1 || !reached) $display("FAIL pause_no_strobe: got %0d strobes %0d extra bytes want 0/0", strobes, ncap_a - n1); else passed++;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        bad = 0;
        for (int p = 0; p < 64; p++) begin
            if ({cap_a[base+2*p], cap_a[base+2*p+1]} !== exp_open_a(p % 8, p / 8)) bad++;
        end
        checks++; if (ncap_a - base !== 128 || !ok) $display("FAIL pause_bytes: got %0d want 128", ncap_a - base); else passed++;
        checks++; if (bad !== 0) $display("FAIL pause_content: got %0d bad pixels want 0", bad); else passed++;
        checks++; if (done_a_cnt - d0 !== 1) $display("FAIL pause_done_count: got %0d want 1", done_a_cnt - d0); else passed++;
        after = ncap_a;
        repeat (100) @(negedge clk);
        checks++; if (ncap_a !== after || busy_a !== 1'b0) $display("FAIL start_while_busy_queued: got %0d extra bytes busy %b want 0/0", ncap_a - after, busy_a); else passed++;
    endtask

    task automatic test_reset_midframe;
        int base, bad;
        bit reached, ok;
        base = ncap_a;
        reached = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ncap_a - base >= 60) begin
                reached = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        $display("midframe reset at byte %0d", ncap_a - base);
        checks++; if (!reached) $display("FAIL rst_reach_byte60: got %0d bytes want 60", ncap_a - base); else passed++;
        checks++; if (tft_transmit_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_mid_ctrl: got tx %b busy %b done %b want 0/0/0", tft_transmit_a, busy_a, done_a); else passed++;
        checks++; if (tft_data_a !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", tft_data_a); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame_a(3000, base, ok);
        bad = 0;
        for (int p = 0; p < 64; p++) begin
            if ({cap_a[base+2*p], cap_a[base+2*p+1]} !== exp_open_a(p % 8, p / 8)) bad++;
        end
        $display("post-reset frame: bytes %0d bad %0d", ncap_a - base, bad);
        checks++; if (ncap_a - base !== 128 || !ok) $display("FAIL rst_next_bytes: got %0d want 128", ncap_a - base); else passed++;
        checks++; if ({cap_a[base], cap_a[base+1]} !== 16'h07E0) $display("FAIL rst_next_first_px: got %h want 07e0", {cap_a[base], cap_a[base+1]}); else passed++;
        checks++; if (bad !== 0) $display("FAIL rst_next_content: got %0d bad pixels want 0", bad); else passed++;
    endtask

    task automatic test_full_frame_b;
        int base, d0, bad;
        bit ok;
        logic [23:0] e;
        h_b = '1; v_b = '1; food_b = '1;
        base = ncap_b;
        d0 = done_b_cnt;
        ok = 1'b0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (done_b) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        bad = 0;
        for (int p = 0; p < 384; p++) begin
            e = exp_full_b(p % 24, p / 24);
            if ({cap_b[base+3*p], cap_b[base+3*p+1], cap_b[base+3*p+2]} !== e) bad++;
        end
        $display("frame B: bytes %0d bad %0d dones %0d", ncap_b - base, bad, done_b_cnt - d0);
        checks++; if (ncap_b - base !== 1152 || !ok) $display("FAIL b_bytes: got %0d want 1152", ncap_b - base); else passed++;
        checks++; if (done_b_cnt - d0 !== 1 || busy_b !== 1'b0) $display("FAIL b_done_once: got %0d dones busy %b want 1/0", done_b_cnt - d0, busy_b); else passed++;
        checks++; if ({cap_b[base+150], cap_b[base+151], cap_b[base+152]} !== 24'h102030) $display("FAIL b_food_msb_first: got %h want 102030", {cap_b[base+150], cap_b[base+151], cap_b[base+152]}); else passed++;
        checks++; if (bad !== 0) $display("FAIL b_content: got %0d bad pixels want 0", bad); else passed++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_frame;
        test_walls;
        test_food;
        test_pause;
        test_reset_midframe;
        test_full_frame_b;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
